// File: rtl/bus_term_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_term_pkg
// Purpose  : Shared constants and the destination-ID extractor for bus_term_if.
// Revision : 1.0
// ============================================================================
package bus_term_pkg;

    localparam int              ID_W          = 8;
    localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;
    localparam int              MAX_W         = 256;

    // Callers zero-extend their word to MAX_W and pass their real width.
    function automatic logic [ID_W-1:0] dest_of(input logic [MAX_W-1:0] word,
                                                input int unsigned      width);
        return ID_W'(word >> (width - ID_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_term_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_term_fifo
// Purpose  : First-word-fall-through FIFO with wrap-bit pointers.
// Revision : 1.0
// ============================================================================
module bus_term_fifo #(
    parameter int ancho_pal = 32,
    parameter int depth     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr,
    input  logic [ancho_pal-1:0]         din,
    input  logic                         rd,
    output logic [ancho_pal-1:0]         dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(depth + 1);

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [ancho_pal-1:0] mem_q [depth];
    logic                 do_wr;
    logic                 do_rd;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd && !empty;
        // A pop on the same edge frees the slot, so a full FIFO still takes the write.
        do_wr    = wr && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
        count    = CW'(wr_ptr_q - rd_ptr_q);
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_term_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_term_if
// Purpose  : Terminal-side TX/RX buffering and address filter for one bus port.
// Revision : 1.0
// ============================================================================
module bus_term_if
    import bus_term_pkg::*;
#(
    parameter int              ancho_pal = 32,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] id        = 8'd0,
    parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ancho_pal-1:0]       wr_data,
    output logic                       tx_full,
    output logic [$clog2(depth+1)-1:0] tx_count,
    output logic                       pndng,
    output logic [ancho_pal-1:0]       D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [ancho_pal-1:0]       D_push,
    input  logic                       rd_en,
    output logic [ancho_pal-1:0]       rd_data,
    output logic                       rd_valid,
    output logic [$clog2(depth+1)-1:0] rx_count,
    output logic [7:0]                 tx_ovf_cnt,
    output logic [7:0]                 rx_drop_cnt
);

    logic            tx_empty_w;
    logic            tx_full_w;
    logic            rx_empty_w;
    logic            rx_full_w;
    logic [ID_W-1:0] rx_dest_w;
    logic            rx_accept_w;
    logic            rx_drop_w;
    logic            tx_drop_w;
    logic [7:0]      tx_ovf_q, tx_ovf_d;
    logic [7:0]      rx_drop_q, rx_drop_d;

    always_comb begin
        rx_dest_w   = dest_of(MAX_W'(D_push), ancho_pal);
        rx_accept_w = push && ((rx_dest_w == id) || (rx_dest_w == broadcast));
        // When full the FIFO is non-empty, so any rd_en frees a slot this edge.
        rx_drop_w   = rx_accept_w && rx_full_w && !rd_en;
        tx_drop_w   = wr_en && tx_full_w && !pop;

        tx_ovf_d = tx_ovf_q;
        if (tx_drop_w && (tx_ovf_q != 8'hFF)) begin
            tx_ovf_d = tx_ovf_q + 8'd1;
        end
        rx_drop_d = rx_drop_q;
        if (rx_drop_w && (rx_drop_q != 8'hFF)) begin
            rx_drop_d = rx_drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf_q  <= '0;
            rx_drop_q <= '0;
        end else begin
            tx_ovf_q  <= tx_ovf_d;
            rx_drop_q <= rx_drop_d;
        end
    end

    bus_term_fifo #(
        .ancho_pal (ancho_pal),
        .depth     (depth)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .wr    (wr_en),
        .din   (wr_data),
        .rd    (pop),
        .dout  (D_pop),
        .empty (tx_empty_w),
        .full  (tx_full_w),
        .count (tx_count)
    );

    bus_term_fifo #(
        .ancho_pal (ancho_pal),
        .depth     (depth)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .wr    (rx_accept_w),
        .din   (D_push),
        .rd    (rd_en),
        .dout  (rd_data),
        .empty (rx_empty_w),
        .full  (rx_full_w),
        .count (rx_count)
    );

    assign pndng       = !tx_empty_w;
    assign rd_valid    = !rx_empty_w;
    assign tx_full     = tx_full_w;
    assign tx_ovf_cnt  = tx_ovf_q;
    assign rx_drop_cnt = rx_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_term_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_term_if
// Purpose  : Self-checking bench for bus_term_if against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_bus_term_if;

    localparam int         W      = 32;
    localparam int         DEPTH  = 8;
    localparam logic [7:0] MY_ID  = 8'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          tx_full;
    logic [3:0]    tx_count;
    logic          pndng;
    logic [W-1:0]  D_pop;
    logic          pop;
    logic          push;
    logic [W-1:0]  D_push;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [3:0]    rx_count;
    logic [7:0]    tx_ovf_cnt;
    logic [7:0]    rx_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];
    int           m_ovf;
    int           m_drop;

    always #5 clk = ~clk;

    bus_term_if #(
        .ancho_pal (W),
        .depth     (DEPTH),
        .id        (MY_ID),
        .broadcast (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .tx_full     (tx_full),
        .tx_count    (tx_count),
        .pndng       (pndng),
        .D_pop       (D_pop),
        .pop         (pop),
        .push        (push),
        .D_push      (D_push),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rx_count    (rx_count),
        .tx_ovf_cnt  (tx_ovf_cnt),
        .rx_drop_cnt (rx_drop_cnt)
    );

    // Drives one cycle of stimulus, advances the model at the edge, returns 1 ns later.
    task automatic tick(input logic w, input logic [W-1:0] wd, input logic p,
                        input logic ps, input logic [W-1:0] pd, input logic r);
        bit pop_ok, wr_ok, acc, rd_ok, st;
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = pd; rd_en = r;
        @(posedge clk);
        pop_ok = p && (tx_q.size() != 0);
        wr_ok  = w && ((tx_q.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(tx_q.pop_front());
        if (wr_ok) tx_q.push_back(wd);
        else if (w && m_ovf < 255) m_ovf++;
        acc   = ps && ((pd[31:24] == MY_ID) || (pd[31:24] == 8'hFF));
        rd_ok = r && (rx_q.size() != 0);
        st    = acc && ((rx_q.size() < DEPTH) || rd_ok);
        if (rd_ok) void'(rx_q.pop_front());
        if (st) rx_q.push_back(pd);
        else if (acc && m_drop < 255) m_drop++;
        #1;
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; wr_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rd_en = 1'b0;
        tx_q.delete(); rx_q.delete(); m_ovf = 0; m_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({pndng, rd_valid, tx_full} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {pndng, rd_valid, tx_full}); end
        n_cmp++; if ({tx_count, rx_count} !== 8'h00) begin n_err++; $display("FAIL reset_counts: got %h expected 00", {tx_count, rx_count}); end
        n_cmp++; if ({tx_ovf_cnt, rx_drop_cnt} !== 16'h0000) begin n_err++; $display("FAIL reset_err_cnts: got %h expected 0000", {tx_ovf_cnt, rx_drop_cnt}); end
        n_cmp++; if ({D_pop, rd_data} !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {D_pop, rd_data}); end
        #2 reset = 1'b1;
    endtask

    task automatic test_tx_basic();
        tick(1, 32'h0100_00AA, 0, 0, 0, 0);
        n_cmp++; if (pndng !== 1'b1) begin n_err++; $display("FAIL tx_basic_pndng: got %b expected 1", pndng); end
        n_cmp++; if (D_pop !== 32'h0100_00AA) begin n_err++; $display("FAIL tx_basic_dpop: got %h expected 010000aa", D_pop); end
        n_cmp++; if (tx_count !== 4'd1) begin n_err++; $display("FAIL tx_basic_count: got %0d expected 1", tx_count); end
        tick(0, 0, 1, 0, 0, 0);
        n_cmp++; if (pndng !== 1'b0) begin n_err++; $display("FAIL tx_basic_pndng_after_pop: got %b expected 0", pndng); end
        n_cmp++; if (tx_count !== 4'd0) begin n_err++; $display("FAIL tx_basic_count_after_pop: got %0d expected 0", tx_count); end
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < 9; i++) begin
            tick(1, W'(i), 0, 0, 0, 0);
            if (i == 7) begin
                n_cmp++; if (tx_full !== 1'b1) begin n_err++; $display("FAIL tx_ovf_full: got %b expected 1", tx_full); end
            end
        end
        n_cmp++; if (tx_ovf_cnt !== 8'd1) begin n_err++; $display("FAIL tx_ovf_cnt: got %0d expected 1", tx_ovf_cnt); end
        n_cmp++; if (tx_count !== 4'd8) begin n_err++; $display("FAIL tx_ovf_count: got %0d expected 8", tx_count); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (D_pop !== W'(i)) begin n_err++; $display("FAIL tx_ovf_order[%0d]: got %h expected %h", i, D_pop, W'(i)); end
            tick(0, 0, 1, 0, 0, 0);
        end
        n_cmp++; if (pndng !== 1'b0) begin n_err++; $display("FAIL tx_ovf_drained: got %b expected 0", pndng); end
    endtask

    task automatic test_tx_full_wr_pop();
        logic [W-1:0] exp;
        for (int i = 0; i < 8; i++) tick(1, 32'h100 + W'(i), 0, 0, 0, 0);
        tick(1, 32'hBEEF, 1, 0, 0, 0);
        n_cmp++; if (tx_count !== 4'd8) begin n_err++; $display("FAIL tx_fullwp_count: got %0d expected 8", tx_count); end
        n_cmp++; if (tx_ovf_cnt !== 8'd1) begin n_err++; $display("FAIL tx_fullwp_ovf: got %0d expected 1", tx_ovf_cnt); end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 32'h101 + W'(i) : 32'hBEEF;
            n_cmp++; if (D_pop !== exp) begin n_err++; $display("FAIL tx_fullwp_order[%0d]: got %h expected %h", i, D_pop, exp); end
            tick(0, 0, 1, 0, 0, 0);
        end
    endtask

    task automatic test_rx_filter();
        tick(0, 0, 0, 1, 32'h0200_1234, 0);
        tick(0, 0, 0, 1, 32'h0300_5678, 0);
        tick(0, 0, 0, 1, 32'hFF00_9ABC, 0);
        n_cmp++; if (rx_count !== 4'd2) begin n_err++; $display("FAIL rx_filter_count: got %0d expected 2", rx_count); end
        n_cmp++; if (rd_data !== 32'h0200_1234) begin n_err++; $display("FAIL rx_filter_first: got %h expected 02001234", rd_data); end
        tick(0, 0, 0, 0, 0, 1);
        n_cmp++; if (rd_data !== 32'hFF00_9ABC) begin n_err++; $display("FAIL rx_filter_second: got %h expected ff009abc", rd_data); end
        tick(0, 0, 0, 0, 0, 1);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rx_filter_empty: got %b expected 0", rd_valid); end
        n_cmp++; if (rx_drop_cnt !== 8'd0) begin n_err++; $display("FAIL rx_filter_drop: got %0d expected 0", rx_drop_cnt); end
    endtask

    task automatic test_rx_drop();
        logic [W-1:0] exp;
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 32'h0200_0000 + W'(i), 0);
        n_cmp++; if (rx_count !== 4'd8) begin n_err++; $display("FAIL rx_drop_fill: got %0d expected 8", rx_count); end
        tick(0, 0, 0, 1, 32'h0200_0008, 0);
        n_cmp++; if (rx_drop_cnt !== 8'd1) begin n_err++; $display("FAIL rx_drop_cnt: got %0d expected 1", rx_drop_cnt); end
        tick(0, 0, 0, 1, 32'hFF00_0009, 1);
        n_cmp++; if (rx_count !== 4'd8) begin n_err++; $display("FAIL rx_drop_rdpush_count: got %0d expected 8", rx_count); end
        n_cmp++; if (rx_drop_cnt !== 8'd1) begin n_err++; $display("FAIL rx_drop_rdpush_cnt: got %0d expected 1", rx_drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 32'h0200_0001 + W'(i) : 32'hFF00_0009;
            n_cmp++; if (rd_data !== exp) begin n_err++; $display("FAIL rx_drop_order[%0d]: got %h expected %h", i, rd_data, exp); end
            tick(0, 0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) tick(1, 32'hA0 + W'(i), 0, 1, 32'hFF00_0000 | W'(i), 0);
        repeat (260) tick(1, 32'hDEAD, 0, 1, 32'h0200_DEAD, 0);
        n_cmp++; if (tx_ovf_cnt !== 8'd255) begin n_err++; $display("FAIL sat_tx_ovf: got %0d expected 255", tx_ovf_cnt); end
        n_cmp++; if (rx_drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_rx_drop: got %0d expected 255", rx_drop_cnt); end
        n_cmp++; if ({tx_count, rx_count} !== 8'h88) begin n_err++; $display("FAIL sat_counts: got %h expected 88", {tx_count, rx_count}); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (D_pop !== 32'hA0 + W'(i)) begin n_err++; $display("FAIL sat_tx_order[%0d]: got %h expected %h", i, D_pop, 32'hA0 + W'(i)); end
            n_cmp++; if (rd_data !== (32'hFF00_0000 | W'(i))) begin n_err++; $display("FAIL sat_rx_order[%0d]: got %h expected %h", i, rd_data, 32'hFF00_0000 | W'(i)); end
            tick(0, 0, 1, 0, 0, 1);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1, 32'h300 + W'(i), 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) tick(0, 0, 0, 1, 32'h0200_0400 + W'(i), 0);
        n_cmp++; if ({pndng, rd_valid} !== 2'b11) begin n_err++; $display("FAIL areset_pre_flags: got %b expected 11", {pndng, rd_valid}); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({pndng, rd_valid} !== 2'b00) begin n_err++; $display("FAIL areset_flags: got %b expected 00", {pndng, rd_valid}); end
        n_cmp++; if ({tx_count, rx_count} !== 8'h00) begin n_err++; $display("FAIL areset_counts: got %h expected 00", {tx_count, rx_count}); end
        n_cmp++; if ({tx_ovf_cnt, rx_drop_cnt} !== 16'h0000) begin n_err++; $display("FAIL areset_err_cnts: got %h expected 0000", {tx_ovf_cnt, rx_drop_cnt}); end
        n_cmp++; if ({D_pop, rd_data} !== 64'h0) begin n_err++; $display("FAIL areset_data: got %h expected 0", {D_pop, rd_data}); end
        tx_q.delete(); rx_q.delete(); m_ovf = 0; m_drop = 0;
        #2 reset = 1'b1;
        tick(0, 0, 0, 0, 0, 0);
        n_cmp++; if ({pndng, rd_valid} !== 2'b00) begin n_err++; $display("FAIL areset_post_flags: got %b expected 00", {pndng, rd_valid}); end
    endtask

    task automatic test_random();
        logic [W-1:0] pd, exp_dpop, exp_rd;
        logic [7:0]   dest;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    dest = MY_ID;
                2:       dest = 8'hFF;
                default: dest = 8'($urandom_range(3, 254));
            endcase
            pd = {dest, 24'($urandom)};
            tick($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) < 6, pd, $urandom_range(0, 9) < 4);
            exp_dpop = (tx_q.size() != 0) ? tx_q[0] : '0;
            exp_rd   = (rx_q.size() != 0) ? rx_q[0] : '0;
            n_cmp++; if (D_pop !== exp_dpop) begin n_err++; $display("FAIL rand_dpop[%0d]: got %h expected %h", n, D_pop, exp_dpop); end
            n_cmp++; if ({pndng, tx_full, tx_count} !== {tx_q.size() != 0, tx_q.size() == DEPTH, 4'(tx_q.size())}) begin n_err++; $display("FAIL rand_tx_state[%0d]: got %b/%b/%0d expected size %0d", n, pndng, tx_full, tx_count, tx_q.size()); end
            n_cmp++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL rand_rd_data[%0d]: got %h expected %h", n, rd_data, exp_rd); end
            n_cmp++; if ({rd_valid, rx_count} !== {rx_q.size() != 0, 4'(rx_q.size())}) begin n_err++; $display("FAIL rand_rx_state[%0d]: got %b/%0d expected size %0d", n, rd_valid, rx_count, rx_q.size()); end
            n_cmp++; if ({tx_ovf_cnt, rx_drop_cnt} !== {8'(m_ovf), 8'(m_drop)}) begin n_err++; $display("FAIL rand_err_cnts[%0d]: got %0d/%0d expected %0d/%0d", n, tx_ovf_cnt, rx_drop_cnt, m_ovf, m_drop); end
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_tx_full_wr_pop();
        test_rx_filter();
        test_rx_drop();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_term_if.md
Name: bus_term_if

Overview:
- Per-terminal hardware interface between a local agent and one port of the bus generator/arbiter `bs_gnrtr_n_rbtr`.
- TX side: buffers words written by the agent and presents them to the bus through the `pndng`/`pop`/`D_pop` handshake.
- RX side: accepts the bus `push`/`D_push` strobe, keeps only words addressed to this terminal or to broadcast, and buffers them for the agent.
- One instance per terminal, placed directly upstream/downstream of the bus.

Parameters:
- ancho_pal, 32, word width in bits; the top 8 bits are the destination ID.
- depth, 8, entries per FIFO (TX and RX); must be a power of 2, at least 2.
- id, 0, this terminal's 8-bit ID.
- broadcast, 8'hFF, destination ID that every terminal accepts.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  agent write strobe into the TX FIFO.
- wr_data  in  ancho_pal  agent write data.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(depth+1)  TX occupancy.
- pndng  out  1  TX FIFO non-empty (to bus).
- D_pop  out  ancho_pal  TX head word (to bus).
- pop  in  1  bus consumes the TX head.
- push  in  1  bus delivers a word.
- D_push  in  ancho_pal  delivered word.
- rd_en  in  1  agent reads the RX head.
- rd_data  out  ancho_pal  RX head word.
- rd_valid  out  1  RX FIFO non-empty.
- rx_count  out  $clog2(depth+1)  RX occupancy.
- tx_ovf_cnt  out  8  saturating count of TX writes dropped because the FIFO was full.
- rx_drop_cnt  out  8  saturating count of accepted-address words dropped because RX was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pointers and counts go to 0; pndng=0, rd_valid=0, tx_full=0.
  - tx_ovf_cnt=0, rx_drop_cnt=0.
  - D_pop and rd_data read 0 while their FIFO is empty.
  - Asserting reset mid-operation discards all contents immediately.
  - Deassertion takes effect on the next rising clk edge.
- FIFOs are first-word-fall-through:
  - D_pop equals the TX head combinationally while pndng=1.
  - rd_data equals the RX head while rd_valid=1.
- TX write:
  - wr_en=1 and not full: the word is stored at the clk edge.
  - pndng rises the cycle after the first write into an empty FIFO (write-to-pndng latency 1).
- TX pop:
  - pop=1 with pndng=1: the head is removed at the edge, and the next head appears in the following cycle.
  - pop=1 with pndng=0: ignored, no state change.
- TX simultaneous wr_en and pop:
  - Not empty: both happen and the count is unchanged; this includes the full case, where the write is accepted because the pop frees a slot.
  - Empty: the write is accepted and the pop is ignored.
- TX overflow: wr_en=1 while full with no pop drops the word; tx_ovf_cnt increments and saturates at 255.
- RX filter: on push=1, dest = D_push[ancho_pal-1 -: 8].
  - The word is accepted only if dest==id or dest==broadcast.
  - Any other dest is silently ignored and no counter changes.
- RX store:
  - An accepted word with RX not full is stored; rd_valid follows 1 cycle later.
  - An accepted word with RX full and rd_en=0 is dropped; rx_drop_cnt increments, saturating at 255.
  - RX full with rd_en=1 on the same edge: the word is stored.
- RX read:
  - rd_en=1 with rd_valid=1 pops the head.
  - rd_en=1 with rd_valid=0 is ignored.
- Pointers:
  - Width $clog2(depth)+1; wrap-around is natural modulo 2·depth.
  - Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Counts equal the write pointer minus the read pointer, taken modulo 2·depth.
- No combinational path from pop to pndng or from push to rd_valid; both flags are derived from registered pointers.

Decomposition:
- Package bus_term_pkg holds:
  - ID_W=8.
  - Function dest_of(word), returning the top ID_W bits.
  - Constant BCAST_DEFAULT=8'hFF.
- Sub-module bus_term_fifo (parameters ancho_pal and depth; ports wr, din, rd, dout, empty, full, count) is instantiated twice.
- The top level contains only the address filter, the overflow/drop counters and the port mapping.

Test Plan:
- Reset, then write 32'h0100_00AA with wr_en for 1 cycle -> pndng=1 the next cycle, D_pop=32'h0100_00AA; pop for 1 cycle -> pndng=0, tx_count=0.
- Write 9 words 32'h0000_0000..32'h0000_0008 back-to-back, depth=8, no pop -> tx_full=1 after word 8, word 8 dropped, tx_ovf_cnt=1; 8 pops return 0..7 in order.
- With TX full, assert wr_en and pop in the same cycle -> tx_count stays 8, tx_ovf_cnt unchanged, and the new word appears last after draining.
- id=2: push D_push=32'h0200_1234, then 32'h0300_5678, then 32'hFF00_9ABC -> rx_count=2, rd_data order 32'h0200_1234 then 32'hFF00_9ABC, rx_drop_cnt=0.
- Fill RX with 8 accepted words, then push a 9th with rd_en=0 -> rx_drop_cnt=1; repeat with rd_en=1 -> word stored, rx_count stays 8.
- Write 3 TX words and 2 RX words, then pulse reset low for 3 ns between edges -> pndng and rd_valid go 0 immediately, counts 0, and the counters are cleared.
